// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: accept, execute, report, then back to idle.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        last_owner;
  logic        owner;
  logic        win;
  logic        any_req;
  logic        bad_op;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  assign any_req = req0 | req1;
  assign bad_op  = (op_q[2:1] == 2'b11);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win = last_owner;
    unique case (1'b1)
      (req0 & req1):  win = ~last_owner;
      (req0 & ~req1): win = 1'b0;
      (~req0 & req1): win = 1'b1;
      default:        win = last_owner;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_req) nxt = EXEC;
      EXEC:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= 1'b1;
      owner      <= 1'b0;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      result     <= 32'd0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= win;
            last_owner <= win;
            op_q       <= win ? op1 : op0;
            a_q        <= win ? a1 : a0;
            b_q        <= win ? b1 : b0;
          end
        end
        EXEC: begin
          result <= bad_op ? 32'd0 : alu_out;
          err    <= bad_op;
        end
        DONE:    err <= 1'b0;
        default: err <= 1'b0;
      endcase
    end
  end

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = 3'd0;
    busy   = (state != IDLE);
    if (state == EXEC) begin
      gnt0   = ~owner;
      gnt1   = owner;
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
    if (state == DONE) begin
      done0 = ~owner;
      done1 = owner;
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 SHALL provide port: clk  input  1  system clock.
REQ-003 SHALL provide port: reset  input  1  asynchronous active-low reset.
REQ-004 SHALL provide ports: req0, req1  input  1 each  operation request from requester 0 and requester 1.
REQ-005 SHALL provide ports: op0, op1  input  3 each  requested ALUOp.
REQ-006 SHALL provide ports: a0, b0, a1, b1  input  32 each  requested operands.
REQ-007 SHALL provide ports: alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-008 SHALL provide port: alu_op  output  3  ALUOp driven to the shared ALU.
REQ-009 SHALL provide port: alu_out  input  32  result returned by the shared ALU.
REQ-010 SHALL provide ports: gnt0, gnt1  output  1 each  one-cycle acceptance pulse.
REQ-011 SHALL provide ports: done0, done1  output  1 each  one-cycle completion pulse.
REQ-012 SHALL provide port: result  output  32  registered ALU result of the last completed operation.
REQ-013 SHALL provide port: err  output  1  unsupported-op flag, valid only while done0 or done1 is high.
REQ-014 SHALL provide port: busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-016 In IDLE, if neither request is high at the edge, the FSM SHALL remain in IDLE.
REQ-017 In IDLE, if any request is high at the edge: winner selected, winner's op/a/b latched, owner recorded, FSM SHALL enter EXEC.
REQ-018 Arbitration SHALL be round-robin using register last_owner: when both requests are high, the requester not equal to last_owner wins; when one is high, that one wins; last_owner SHALL update to the winner.
REQ-019 In EXEC, alu_a/alu_b/alu_op SHALL equal the latched values; gnt of the owner SHALL be high for exactly this cycle.
REQ-020 At the EXEC edge: result <= alu_out for ops 3'b000-3'b101, and err <= 0; the FSM SHALL then enter DONE.
REQ-021 At the EXEC edge, for ops 3'b110/3'b111: result <= 32'h00000000 and err <= 1; the FSM SHALL then enter DONE.
REQ-022 In DONE, done of the owner SHALL be high for exactly one cycle; the FSM SHALL return to IDLE unconditionally.
REQ-023 Latency SHALL be as follows: request sampled at edge N; gnt high in cycle N+1; done and result valid in cycle N+2. Maximum throughput SHALL be one operation per 3 cycles.
REQ-024 result SHALL hold its value until the next EXEC capture; err SHALL be cleared on leaving DONE.
REQ-025 Outside EXEC, alu_a, alu_b and alu_op SHALL be driven to 0.
REQ-026 Requests SHALL be ignored in EXEC and DONE; changes to req/op/a/b after the acceptance edge SHALL NOT affect the operation in flight.
REQ-027 A requester SHALL hold req and operands until it sees its gnt; if req is still high in IDLE after its done, the arbiter SHALL treat it as a new request.
REQ-028 gnt0 and gnt1 SHALL never be high simultaneously; likewise done0 and done1.

Reset
REQ-029 On reset low, immediately and regardless of clk: FSM=IDLE, last_owner=1, result=0, err=0, gnt*/done*/busy=0, alu_a/alu_b/alu_op=0.
REQ-030 Reset asserted in EXEC or DONE SHALL abort the operation with no done pulse; the first request after release SHALL be arbitrated normally (requester 0 first on tie).

Verification
REQ-031 Scenario: req0=1, op0=000, a0=5, b0=3 -> gnt0 high in cycle N+1, alu_op=000, done0 in cycle N+2, result=8, err=0.
REQ-032 Scenario: req0=req1=1 held, first after reset -> requester 0 served first, then requester 1, then requester 0; gnt pulses 3 cycles apart.
REQ-033 Scenario: req1=1, op1=101, b1=32'h00000080 -> result=32'hFFFFFF80; op1=101, b1=32'h0000007F -> result=32'h0000007F.
REQ-034 Scenario: req0=1, op0=111 -> done0 with err=1, result=0; the next valid op clears err.
REQ-035 Scenario: reset pulsed low during EXEC -> all outputs 0 asynchronously, no done; after release, a new request completes normally.
REQ-036 Scenario: a0 changed in the cycle gnt0 is high (op0=001, a0=10, b0=4 at acceptance) -> result=6.
